// File: rtl/pcie_link_mon_pkg.sv
// Shared LTSSM encodings, link FSM state type and small decode helpers
// for the PCIe link monitor.
package pcie_link_mon_pkg;

  localparam logic [4:0] DETECT_QUIET = 5'h00;
  localparam logic [4:0] POLL_COMPL   = 5'h03;
  localparam logic [4:0] RECOV_LOCK   = 5'h0C;
  localparam logic [4:0] RECOV_CFG    = 5'h0D;
  localparam logic [4:0] RECOV_IDLE   = 5'h0E;
  localparam logic [4:0] L0           = 5'h0F;

  typedef enum logic [1:0] {
    ST_DOWN,
    ST_TRAINING,
    ST_STABLE_WAIT,
    ST_UP
  } link_state_t;

  // States in which an already-qualified link is still considered up.
  function automatic logic is_retained(input logic [4:0] ltssm);
    return (ltssm == RECOV_LOCK) || (ltssm == RECOV_CFG) ||
           (ltssm == RECOV_IDLE) || (ltssm == L0);
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/pcie_sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment
// takes priority and leaves the counter at zero.
module pcie_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_out_buf,
  input  logic         any_rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_out_buf or negedge any_rstn) begin
    if (!any_rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pcie_ltssm_link_monitor.sv
// Debounced PCIe link status from the hard-IP LTSSM debug bus: qualified
// link-up, recovery / link-drop statistics, lane count and board LEDs.
module pcie_ltssm_link_monitor
  import pcie_link_mon_pkg::*;
#(
  parameter int STABLE_CYC = 16,
  parameter int CNT_W      = 16,
  parameter int ALIVE_W    = 25
) (
  input  logic             clk_out_buf,
  input  logic             any_rstn,
  input  logic [8:0]       test_out_icm,
  input  logic             clr_stats,
  output logic [4:0]       ltssm_q,
  output logic             link_up,
  output logic [2:0]       lane_cnt,
  output logic [CNT_W-1:0] recovery_cnt,
  output logic [CNT_W-1:0] linkdown_cnt,
  output logic             alive_led,
  output logic             L0_led,
  output logic             comp_led,
  output logic [3:0]       lane_active_led
);

  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYC - 1);

  link_state_t        state;
  logic [7:0]         stab_cnt;
  logic [3:0]         lanes_q;
  logic [4:0]         ltssm_prev;
  logic [ALIVE_W-1:0] alive_cnt;
  logic               rec_inc;
  logic               down_inc;

  always_ff @(posedge clk_out_buf or negedge any_rstn) begin
    if (!any_rstn) begin
      ltssm_q    <= '0;
      lanes_q    <= '0;
      ltssm_prev <= '0;
    end else begin
      ltssm_q    <= test_out_icm[4:0];
      lanes_q    <= test_out_icm[8:5];
      ltssm_prev <= ltssm_q;
    end
  end

  // lane_cnt is only loaded on edges whose next state is UP, so it reads
  // zero everywhere else without a separate next-state decode.
  always_ff @(posedge clk_out_buf or negedge any_rstn) begin
    if (!any_rstn) begin
      state    <= ST_DOWN;
      stab_cnt <= '0;
      lane_cnt <= '0;
    end else begin
      lane_cnt <= '0;
      case (state)
        ST_DOWN: begin
          if (ltssm_q != DETECT_QUIET) state <= ST_TRAINING;
        end
        ST_TRAINING: begin
          if (ltssm_q == L0) begin
            state    <= ST_STABLE_WAIT;
            stab_cnt <= '0;
          end else if (ltssm_q == DETECT_QUIET) begin
            state <= ST_DOWN;
          end
        end
        ST_STABLE_WAIT: begin
          if (ltssm_q != L0) begin
            state <= ST_TRAINING;
          end else if (stab_cnt == STAB_LAST) begin
            state    <= ST_UP;
            lane_cnt <= popcount4(lanes_q);
          end else begin
            stab_cnt <= stab_cnt + 8'd1;
          end
        end
        ST_UP: begin
          if (!is_retained(ltssm_q)) state <= ST_DOWN;
          else lane_cnt <= popcount4(lanes_q);
        end
        default: state <= ST_DOWN;
      endcase
    end
  end

  assign link_up  = (state == ST_UP);
  assign rec_inc  = (state == ST_UP) && (ltssm_prev == L0) && (ltssm_q == RECOV_LOCK);
  assign down_inc = (state == ST_UP) && !is_retained(ltssm_q);

  pcie_sat_counter #(.W(CNT_W)) u_recovery_cnt (
    .clk_out_buf (clk_out_buf),
    .any_rstn    (any_rstn),
    .inc         (rec_inc),
    .clr         (clr_stats),
    .q           (recovery_cnt)
  );

  pcie_sat_counter #(.W(CNT_W)) u_linkdown_cnt (
    .clk_out_buf (clk_out_buf),
    .any_rstn    (any_rstn),
    .inc         (down_inc),
    .clr         (clr_stats),
    .q           (linkdown_cnt)
  );

  // Heartbeat blinks four times faster while there is no link.
  always_ff @(posedge clk_out_buf or negedge any_rstn) begin
    if (!any_rstn) begin
      alive_cnt       <= '0;
      alive_led       <= 1'b0;
      L0_led          <= 1'b0;
      comp_led        <= 1'b0;
      lane_active_led <= '0;
    end else begin
      alive_cnt       <= alive_cnt + ALIVE_W'(1);
      alive_led       <= link_up ? alive_cnt[ALIVE_W-1] : alive_cnt[ALIVE_W-3];
      L0_led          <= ~link_up;
      comp_led        <= ~(ltssm_q == POLL_COMPL);
      lane_active_led <= ~lanes_q;
    end
  end

endmodule

// File: tb/tb_pcie_ltssm_link_monitor.sv
// Directed plus randomized checks of the link monitor against a
// behavioural model of the link qualification rules.
module tb_pcie_ltssm_link_monitor;

  localparam int STABLE_CYC = 16;
  localparam int CNT_W      = 2;
  localparam int ALIVE_W    = 6;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             clk_out_buf = 1'b0;
  logic             any_rstn = 1'b0;
  logic [8:0]       test_out_icm = '0;
  logic             clr_stats = 1'b0;
  logic [4:0]       ltssm_q;
  logic             link_up;
  logic [2:0]       lane_cnt;
  logic [CNT_W-1:0] recovery_cnt;
  logic [CNT_W-1:0] linkdown_cnt;
  logic             alive_led;
  logic             L0_led;
  logic             comp_led;
  logic [3:0]       lane_active_led;

  pcie_ltssm_link_monitor #(
    .STABLE_CYC (STABLE_CYC),
    .CNT_W      (CNT_W),
    .ALIVE_W    (ALIVE_W)
  ) dut (
    .clk_out_buf     (clk_out_buf),
    .any_rstn        (any_rstn),
    .test_out_icm    (test_out_icm),
    .clr_stats       (clr_stats),
    .ltssm_q         (ltssm_q),
    .link_up         (link_up),
    .lane_cnt        (lane_cnt),
    .recovery_cnt    (recovery_cnt),
    .linkdown_cnt    (linkdown_cnt),
    .alive_led       (alive_led),
    .L0_led          (L0_led),
    .comp_led        (comp_led),
    .lane_active_led (lane_active_led)
  );

  always #5 clk_out_buf = ~clk_out_buf;

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  // Model: link up/down flags and the length of the current L0 run since
  // training began; statistics and LEDs derived from those.
  bit         m_up, m_down;
  int         m_run, m_rec, m_ld, m_alive;
  logic [4:0] m_q, m_prevq;
  logic [3:0] m_lanes;
  int         e_lane_cnt;
  logic       e_L0_led, e_comp_led, e_alive_led;
  logic [3:0] e_lane_led;

  function automatic bit retained(input logic [4:0] q);
    return (q >= 5'd12) && (q <= 5'd15);
  endfunction

  function automatic int ones(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_up = 0; m_down = 1; m_run = 0; m_rec = 0; m_ld = 0; m_alive = 0;
    m_q = '0; m_prevq = '0; m_lanes = '0;
    e_lane_cnt = 0; e_L0_led = 0; e_comp_led = 0; e_alive_led = 0; e_lane_led = '0;
  endtask

  task automatic check_all();
    chk("ltssm_q", 32'(ltssm_q), 32'(m_q));
    chk("link_up", 32'(link_up), 32'(m_up));
    chk("lane_cnt", 32'(lane_cnt), 32'(e_lane_cnt));
    chk("recovery_cnt", 32'(recovery_cnt), 32'(m_rec));
    chk("linkdown_cnt", 32'(linkdown_cnt), 32'(m_ld));
    chk("L0_led", 32'(L0_led), 32'(e_L0_led));
    chk("comp_led", 32'(comp_led), 32'(e_comp_led));
    chk("lane_active_led", 32'(lane_active_led), 32'(e_lane_led));
    chk("alive_led", 32'(alive_led), 32'(e_alive_led));
  endtask

  task automatic step(input logic [4:0] st, input logic [3:0] ln, input logic clr);
    bit old_up;
    int old_alive;
    test_out_icm = {ln, st};
    clr_stats    = clr;
    @(posedge clk_out_buf);
    old_up    = m_up;
    old_alive = m_alive;
    if (m_up) begin
      if (!retained(m_q)) begin
        m_up = 0; m_down = 1;
        if (m_ld < CMAX) m_ld++;
      end else if (m_prevq == 5'h0F && m_q == 5'h0C) begin
        if (m_rec < CMAX) m_rec++;
      end
    end else if (m_down) begin
      if (m_q != 5'h00) begin m_down = 0; m_run = 0; end
    end else if (m_q == 5'h0F) begin
      m_run++;
      if (m_run == STABLE_CYC + 1) begin m_up = 1; m_run = 0; end
    end else begin
      if (m_q == 5'h00 && m_run == 0) m_down = 1;
      m_run = 0;
    end
    if (clr) begin m_rec = 0; m_ld = 0; end
    e_lane_cnt  = m_up ? ones(m_lanes) : 0;
    e_L0_led    = ~old_up;
    e_comp_led  = ~(m_q == 5'h03);
    e_lane_led  = ~m_lanes;
    e_alive_led = old_up ? old_alive[ALIVE_W-1] : old_alive[ALIVE_W-3];
    m_alive     = (old_alive + 1) % (1 << ALIVE_W);
    m_prevq     = m_q;
    m_q         = st;
    m_lanes     = ln;
    @(negedge clk_out_buf);
    nstep++;
    $display("step %0d in=%02h lanes=%b clr=%0d link_up=%0d lane_cnt=%0d rec=%0d ld=%0d",
             nstep, st, ln, clr, link_up, lane_cnt, recovery_cnt, linkdown_cnt);
    check_all();
  endtask

  task automatic recover_round();
    step(5'h0C, 4'hF, 1'b0); chk("up_in_recov", 32'(link_up), 32'd1);
    step(5'h0D, 4'hF, 1'b0); chk("up_in_recov", 32'(link_up), 32'd1);
    step(5'h0E, 4'hF, 1'b0); chk("up_in_recov", 32'(link_up), 32'd1);
    step(5'h0F, 4'hF, 1'b0); chk("up_in_recov", 32'(link_up), 32'd1);
  endtask

  initial begin
    int kind, len;
    logic [4:0] st;
    model_reset();
    repeat (3) @(negedge clk_out_buf);
    check_all();
    chk("reset_link_up", 32'(link_up), 32'd0);
    any_rstn = 1'b1;

    // Clean link-up
    step(5'h00, 4'hF, 1'b0); step(5'h00, 4'hF, 1'b0);
    step(5'h02, 4'hF, 1'b0); step(5'h04, 4'hF, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      step(5'h0F, 4'hF, 1'b0);
      if (i == 17) chk("linkup_edge17", 32'(link_up), 32'd0);
      if (i == 18) chk("linkup_edge18", 32'(link_up), 32'd1);
    end
    chk("lane_cnt_4", 32'(lane_cnt), 32'd4);
    step(5'h0F, 4'hF, 1'b0);
    chk("lane_led_lit", 32'(lane_active_led), 32'd0);
    chk("L0_led_lit", 32'(L0_led), 32'd0);

    // Recovery while up
    for (int r = 0; r < 3; r++) recover_round();
    chk("recovery_3", 32'(recovery_cnt), 32'd3);

    // Link drop
    step(5'h00, 4'hF, 1'b0);
    chk("drop_edge1", 32'(link_up), 32'd1);
    step(5'h00, 4'hF, 1'b0);
    chk("drop_edge2", 32'(link_up), 32'd0);
    chk("linkdown_1", 32'(linkdown_cnt), 32'd1);
    chk("drop_lane_cnt", 32'(lane_cnt), 32'd0);
    repeat (20) step(5'h00, 4'h0, 1'b0);

    // Clear, then glitch during qualification
    step(5'h00, 4'h3, 1'b1);
    chk("clr_rec", 32'(recovery_cnt), 32'd0);
    chk("clr_ld", 32'(linkdown_cnt), 32'd0);
    repeat (10) step(5'h0F, 4'h3, 1'b0);
    step(5'h0E, 4'h3, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      step(5'h0F, 4'h3, 1'b0);
      if (i == 17) chk("glitch_edge17", 32'(link_up), 32'd0);
      if (i == 18) chk("glitch_edge18", 32'(link_up), 32'd1);
    end
    chk("glitch_rec0", 32'(recovery_cnt), 32'd0);
    chk("lane_cnt_2", 32'(lane_cnt), 32'd2);

    // Saturation, then clear colliding with a recovery entry
    for (int r = 0; r < 5; r++) recover_round();
    chk("rec_saturated", 32'(recovery_cnt), 32'd3);
    step(5'h0C, 4'h3, 1'b0);
    step(5'h0D, 4'h3, 1'b1);
    chk("clr_beats_inc", 32'(recovery_cnt), 32'd0);
    step(5'h0E, 4'h3, 1'b0);
    step(5'h0F, 4'h3, 1'b0);

    // Compliance
    step(5'h03, 4'h1, 1'b0);
    chk("comp_edge1", 32'(comp_led), 32'd1);
    step(5'h03, 4'h1, 1'b0);
    chk("comp_edge2", 32'(comp_led), 32'd0);
    step(5'h00, 4'h1, 1'b0);

    // Randomized segments
    while (nstep < 1700) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          len = $urandom_range(1, 25);
          repeat (len) step(5'h0F, 4'($urandom), ($urandom_range(0, 49) == 0));
        end
        1: begin
          step(5'h0C, 4'($urandom), 1'b0); step(5'h0D, 4'($urandom), 1'b0);
          step(5'h0E, 4'($urandom), 1'b0); step(5'h0F, 4'($urandom), 1'b0);
        end
        2: begin
          len = $urandom_range(1, 3);
          st  = 5'($urandom_range(0, 31));
          repeat (len) step(st, 4'($urandom), ($urandom_range(0, 49) == 0));
        end
        3: begin
          len = $urandom_range(1, 3);
          repeat (len) step(5'h00, 4'($urandom), 1'b0);
        end
        4: repeat ($urandom_range(1, 2)) step(5'h03, 4'($urandom), 1'b0);
        default: begin
          len = $urandom_range(20, 30);
          repeat (len) step(5'h0F, 4'($urandom), 1'b0);
        end
      endcase
    end

    // Mid-UP asynchronous reset
    step(5'h00, 4'hF, 1'b0); step(5'h00, 4'hF, 1'b0); step(5'h02, 4'hF, 1'b0);
    repeat (20) step(5'h0F, 4'hF, 1'b0);
    chk("pre_reset_up", 32'(link_up), 32'd1);
    #2 any_rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_link_up", 32'(link_up), 32'd0);
    repeat (2) @(negedge clk_out_buf);
    any_rstn = 1'b1;
    repeat (3) step(5'h00, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
